// File: rtl/iob_eth_pkg.sv
// Shared Ethernet MII definitions: FSM encoding, framing constants and the
// latched TX request.
package iob_eth_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_FCS  = 3'd4;
    localparam logic [2:0] ST_IFG  = 3'd5;

    localparam int          PREAMBLE_NIBBLES = 15;
    localparam int          IFG_NIBBLES      = 24;
    localparam logic [7:0]  SFD_BYTE         = 8'hD5;
    localparam logic [3:0]  PRE_NIBBLE       = 4'h5;
    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;

    typedef struct packed {
        logic [10:0] nbytes;
        logic        crc_en;
    } tx_req_t;

endpackage

// File: rtl/iob_eth_crc32_nibble.sv
// Combinational reflected CRC-32 step over one nibble (LSB first); shared
// with the RX path.
module iob_eth_crc32_nibble
    import iob_eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [3:0]  nibble_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {28'd0, nibble_i};
        for (int b = 0; b < 4; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/iob_eth_tx_mii.sv
// MII transmit engine: preamble, SFD, payload from the TX buffer, optional
// FCS and inter-frame gap, one nibble per enabled cycle.
module iob_eth_tx_mii
    import iob_eth_pkg::*;
#(
    parameter int BUFFER_W = 11
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                send_i,
    input  logic                crc_en_i,
    input  logic [10:0]         nbytes_i,
    output logic                ready_o,
    output logic                buf_rd_o,
    output logic [BUFFER_W-1:0] buf_addr_o,
    input  logic [7:0]          buf_data_i,
    output logic                mii_tx_en_o,
    output logic [3:0]          mii_txd_o
);

    logic [2:0]  state;
    logic [4:0]  cnt;
    logic        send_q;
    tx_req_t     req;
    logic [10:0] byte_idx;
    logic        phase;
    logic [7:0]  byte_reg;
    logic [31:0] crc, crc_nxt, fcs_word;
    logic [3:0]  crc_nib;
    logic        last_byte, more_rd;

    // Phase 0 registers the high nibble of the held byte; every other CRC
    // update consumes the low nibble of freshly returned buffer data.
    assign crc_nib   = (state == ST_DATA && !phase) ? byte_reg[7:4] : buf_data_i[3:0];
    assign last_byte = ({1'b0, byte_idx} + 12'd1) == {1'b0, req.nbytes};
    assign more_rd   = ({1'b0, byte_idx} + 12'd2) <  {1'b0, req.nbytes};
    assign fcs_word  = ~crc >> {{1'b0, cnt[2:0]} + 4'd1, 2'b00};

    iob_eth_crc32_nibble u_crc (
        .crc_i    (crc),
        .nibble_i (crc_nib),
        .crc_o    (crc_nxt)
    );

    // Reads are issued one nibble ahead of the byte boundary so the byte is
    // already in hand on the edge that registers its low nibble onto TXD.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            send_q      <= 1'b0;
            req         <= '0;
            byte_idx    <= '0;
            phase       <= 1'b0;
            byte_reg    <= '0;
            crc         <= CRC_INIT;
            ready_o     <= 1'b1;
            buf_rd_o    <= 1'b0;
            buf_addr_o  <= '0;
            mii_tx_en_o <= 1'b0;
            mii_txd_o   <= '0;
        end else if (cke_i) begin
            send_q   <= send_i;
            buf_rd_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send_i && !send_q && nbytes_i != 11'd0) begin
                        req         <= '{nbytes: nbytes_i, crc_en: crc_en_i};
                        ready_o     <= 1'b0;
                        state       <= ST_PRE;
                        cnt         <= '0;
                        mii_tx_en_o <= 1'b1;
                        mii_txd_o   <= PRE_NIBBLE;
                    end
                end
                ST_PRE: begin
                    if (cnt == 5'(PREAMBLE_NIBBLES - 1)) begin
                        state      <= ST_SFD;
                        cnt        <= '0;
                        buf_rd_o   <= 1'b1;
                        buf_addr_o <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_SFD: begin
                    if (cnt == 5'd0) begin
                        cnt       <= 5'd1;
                        mii_txd_o <= SFD_BYTE[7:4];
                    end else begin
                        state     <= ST_DATA;
                        byte_idx  <= '0;
                        phase     <= 1'b0;
                        byte_reg  <= buf_data_i;
                        mii_txd_o <= buf_data_i[3:0];
                        crc       <= crc_nxt;
                        if (req.nbytes != 11'd1) begin
                            buf_rd_o   <= 1'b1;
                            buf_addr_o <= BUFFER_W'(11'd1);
                        end
                    end
                end
                ST_DATA: begin
                    if (!phase) begin
                        phase     <= 1'b1;
                        mii_txd_o <= byte_reg[7:4];
                        crc       <= crc_nxt;
                    end else if (last_byte) begin
                        cnt <= '0;
                        if (req.crc_en) begin
                            state     <= ST_FCS;
                            mii_txd_o <= ~crc[3:0];
                        end else begin
                            state       <= ST_IFG;
                            mii_tx_en_o <= 1'b0;
                            mii_txd_o   <= '0;
                        end
                    end else begin
                        phase     <= 1'b0;
                        byte_idx  <= byte_idx + 11'd1;
                        byte_reg  <= buf_data_i;
                        mii_txd_o <= buf_data_i[3:0];
                        crc       <= crc_nxt;
                        if (more_rd) begin
                            buf_rd_o   <= 1'b1;
                            buf_addr_o <= BUFFER_W'(byte_idx + 11'd2);
                        end
                    end
                end
                ST_FCS: begin
                    if (cnt == 5'd7) begin
                        state       <= ST_IFG;
                        cnt         <= '0;
                        mii_tx_en_o <= 1'b0;
                        mii_txd_o   <= '0;
                    end else begin
                        cnt       <= cnt + 5'd1;
                        mii_txd_o <= fcs_word[3:0];
                    end
                end
                ST_IFG: begin
                    if (cnt == 5'(IFG_NIBBLES - 1)) begin
                        state   <= ST_IDLE;
                        ready_o <= 1'b1;
                        crc     <= CRC_INIT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_tx_mii.sv
// Directed bench for iob_eth_tx_mii: records wire nibbles and buffer reads per
// enabled cycle and checks them against hand-computed frames.
module tb_iob_eth_tx_mii;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        cke_i;
    logic        send_i;
    logic        crc_en_i;
    logic [10:0] nbytes_i;
    logic        ready_o;
    logic        buf_rd_o;
    logic [10:0] buf_addr_o;
    logic [7:0]  buf_data_i = 8'h00;
    logic        mii_tx_en_o;
    logic [3:0]  mii_txd_o;

    iob_eth_tx_mii #(.BUFFER_W(11)) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cke_i       (cke_i),
        .send_i      (send_i),
        .crc_en_i    (crc_en_i),
        .nbytes_i    (nbytes_i),
        .ready_o     (ready_o),
        .buf_rd_o    (buf_rd_o),
        .buf_addr_o  (buf_addr_o),
        .buf_data_i  (buf_data_i),
        .mii_tx_en_o (mii_tx_en_o),
        .mii_txd_o   (mii_txd_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [0:2047];
    always @(posedge clk_i) if (cke_i && buf_rd_o) buf_data_i <= mem[buf_addr_o];

    int checks = 0;
    int failures = 0;
    logic [3:0] nibs[$];
    logic [3:0] exp_nibs[$];
    logic [3:0] ref_nibs[$];
    int addrs[$];
    int en_cnt, busy_cnt, first_en, first_rd, fall_idx, rise_idx;
    bit done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    // Drives one send and records outputs in every enabled cycle until
    // ready_o returns high (or max_cyc raw cycles elapse).
    task automatic run(input int nb, input bit crc, input bit stretch,
                       input int max_cyc, input int toggle_at);
        int ec;
        ec = 0;
        nibs.delete(); addrs.delete();
        en_cnt = 0; busy_cnt = 0; first_en = -1; first_rd = -1;
        fall_idx = -1; rise_idx = -1; done = 0;
        nbytes_i = 11'(nb); crc_en_i = crc; send_i = 1'b1; cke_i = 1'b1;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            @(negedge clk_i);
            if (cke_i) begin
                if (mii_tx_en_o) begin
                    nibs.push_back(mii_txd_o);
                    en_cnt++;
                    if (first_en < 0) first_en = ec;
                end else if (first_en >= 0 && fall_idx < 0) begin
                    fall_idx = ec;
                end
                if (buf_rd_o) begin
                    addrs.push_back(int'(buf_addr_o));
                    if (first_rd < 0) first_rd = ec;
                end
                if (!ready_o) busy_cnt++;
                else if (busy_cnt > 0) begin rise_idx = ec; done = 1; end
                ec++;
            end
            @(posedge clk_i); #1;
            if (stretch) cke_i = ~cke_i;
            if (cyc == toggle_at) send_i = 1'b0;
            else if (toggle_at >= 0 && cyc == toggle_at + 1) send_i = 1'b1;
        end
        cke_i = 1'b1;
    endtask

    task automatic exp_header();
        exp_nibs.delete();
        repeat (15) exp_nibs.push_back(4'h5);
        exp_nibs.push_back(4'h5);
        exp_nibs.push_back(4'hD);
    endtask

    task automatic exp_payload(input int n);
        for (int i = 0; i < n; i++) begin
            exp_nibs.push_back(mem[i][3:0]);
            exp_nibs.push_back(mem[i][7:4]);
        end
    endtask

    task automatic cmp_nibs(input string tag, input int n);
        int bad;
        bad = -1;
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && (i >= nibs.size() || i >= exp_nibs.size() || nibs[i] !== exp_nibs[i]))
                bad = i;
        end
        chk(tag, 64'(bad), 64'(-1));
    endtask

    task automatic cmp_addrs(input string tag, input int n);
        int bad;
        bad = (addrs.size() == n) ? -1 : n;
        for (int i = 0; i < addrs.size(); i++) if (bad < 0 && addrs[i] != i) bad = i;
        chk(tag, 64'(bad), 64'(-1));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        arst_n_i = 1'b1; cke_i = 1'b1; send_i = 1'b0; crc_en_i = 1'b0; nbytes_i = '0;
        #2 arst_n_i = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_tx_en", mii_tx_en_o, 0);
        chk("rst_txd", mii_txd_o, 0);
        chk("rst_buf_rd", buf_rd_o, 0);
        chk("rst_addr", buf_addr_o, 0);
        @(negedge clk_i); arst_n_i = 1'b1;
        idle(2);

        // single byte, no FCS
        mem[0] = 8'hA7;
        run(1, 0, 0, 200, -1);
        chk("b1_done", done, 1);
        chk("b1_en_cnt", en_cnt, 19);
        chk("b1_latency", first_en, 1);
        chk("b1_sfd_rd", first_rd - first_en, 15);
        chk("b1_ifg", rise_idx - fall_idx, 24);
        chk("b1_busy", busy_cnt, 43);
        exp_header(); exp_nibs.push_back(4'h7); exp_nibs.push_back(4'hA);
        chk("b1_len", nibs.size(), exp_nibs.size());
        cmp_nibs("b1_nibs", 19);
        cmp_addrs("b1_addrs", 1);
        send_i = 1'b0; idle(2);

        // "123456789" with FCS
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        run(9, 1, 0, 300, -1);
        chk("crc_done", done, 1);
        chk("crc_en_cnt", en_cnt, 43);
        chk("crc_busy", busy_cnt, 67);
        exp_header(); exp_payload(9);
        exp_nibs.push_back(4'h6); exp_nibs.push_back(4'h2);
        exp_nibs.push_back(4'h9); exp_nibs.push_back(4'h3);
        exp_nibs.push_back(4'h4); exp_nibs.push_back(4'hF);
        exp_nibs.push_back(4'hB); exp_nibs.push_back(4'hC);
        cmp_nibs("crc_nibs", 43);
        cmp_addrs("crc_addrs", 9);
        send_i = 1'b0; idle(2);

        // 4 bytes with FCS, free running then clock-enable stretched
        mem[0] = 8'h10; mem[1] = 8'h32; mem[2] = 8'hFE; mem[3] = 8'h8B;
        run(4, 1, 0, 300, -1);
        chk("fr_done", done, 1);
        chk("fr_en_cnt", en_cnt, 33);
        exp_header(); exp_payload(4);
        cmp_nibs("fr_payload", 25);
        cmp_addrs("fr_addrs", 4);
        ref_nibs = nibs;
        send_i = 1'b0; idle(2);
        run(4, 1, 1, 400, -1);
        chk("st_done", done, 1);
        chk("st_en_cnt", en_cnt, 33);
        chk("st_latency", first_en, 1);
        chk("st_busy", busy_cnt, 57);
        exp_nibs = ref_nibs;
        cmp_nibs("st_nibs", 33);
        cmp_addrs("st_addrs", 4);
        send_i = 1'b0; idle(2);

        // send held high with a re-toggle while busy: only one frame
        run(4, 0, 0, 200, 10);
        chk("hold_done", done, 1);
        chk("hold_en_cnt", en_cnt, 25);
        run(4, 0, 0, 10, -1);
        chk("hold_no_frame", en_cnt, 0);
        chk("hold_ready", busy_cnt, 0);
        send_i = 1'b0; idle(2);
        run(4, 0, 0, 200, -1);
        chk("refire_en_cnt", en_cnt, 25);
        send_i = 1'b0; idle(2);

        // zero-length request is ignored
        run(0, 0, 0, 12, -1);
        chk("z_en_cnt", en_cnt, 0);
        chk("z_rd_cnt", addrs.size(), 0);
        chk("z_busy", busy_cnt, 0);
        send_i = 1'b0; idle(2);

        // reset mid-DATA of a 64-byte frame, then a complete frame
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
        run(64, 0, 0, 40, -1);
        chk("mid_tx_en", mii_tx_en_o, 1);
        #2 arst_n_i = 1'b0;
        #1;
        chk("mid_rst_tx_en", mii_tx_en_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_rd", buf_rd_o, 0);
        @(negedge clk_i); arst_n_i = 1'b1; send_i = 1'b0;
        idle(2);
        run(64, 0, 0, 400, -1);
        chk("post_done", done, 1);
        chk("post_en_cnt", en_cnt, 145);
        exp_header(); exp_payload(64);
        cmp_nibs("post_nibs", 145);
        cmp_addrs("post_addrs", 64);
        send_i = 1'b0; idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
